// File: rtl/hifi4_iram0_arb_pkg.sv
// Shared types and constants for the IRAM0 arbiter.
//   owner_e   : which requester owns a macro access (core or DMA)
//   rd_tag_t  : one read-return tag {valid, owner} carried alongside the
//               macro read latency so the returning data can be routed
//   IRAM0_*   : default geometry of the IRAM0 macro and its read latency
package hifi4_iram0_arb_pkg;

    localparam int IRAM0_AW     = 12;
    localparam int IRAM0_DW     = 128;
    localparam int IRAM0_NWE    = 4;
    localparam int IRAM0_RD_LAT = 2;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

endpackage

// File: rtl/hifi4_iram0_rd_tag_pipe.sv
// Read-return tag pipeline: a DEPTH-stage shift register of rd_tag_t that
// follows the macro read latency, so the tag leaving the last stage lines
// up with the data the macro is returning in the same cycle.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous active-high flush of every stage
//   i_tag   : tag of the access presented to the macro this cycle
//   o_tag   : tag of the access whose read data is returning this cycle
module hifi4_iram0_rd_tag_pipe
    import hifi4_iram0_arb_pkg::*;
#(
    parameter int DEPTH = IRAM0_RD_LAT
) (
    input  logic    i_clk,
    input  logic    i_reset,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '{valid: 1'b0, owner: OWN_CORE};
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/hifi4_iram0_arbiter.sv
// Arbiter sharing the single-ported IRAM0 macro between the core port and
// an inbound DMA port. The core wins by default; a DMA request that keeps
// losing is forced through after DMA_MAX_WAIT consecutive losing cycles.
// Read data is routed back with a tag pipeline matching the macro latency.
// Ports:
//   CLK, Reset            : clock, synchronous active-high reset
//   Core*                 : core request (En/Wr/Addr/WordEn/WrData/LoadStore),
//                           CoreBusy (request not taken, core retries), CoreData
//   Dma*                  : DMA request held until DmaGnt; DmaRdValid/DmaRdData
//                           return read data two cycles after the grant
//   IRam0*                : macro controls and read data
//   ConflictCount         : saturating count of cycles with both requesting
//
// Handshake: the DMA holds DmaReq and its fields stable until a cycle in
// which DmaGnt=1; that cycle is the transfer. The core has no hold
// obligation: a cycle with CoreEn=1 and CoreBusy=0 is the transfer, a cycle
// with CoreBusy=1 is dropped and the core retries.
module hifi4_iram0_arbiter
    import hifi4_iram0_arb_pkg::*;
#(
    parameter int AW           = IRAM0_AW,
    parameter int DW           = IRAM0_DW,
    parameter int NWE          = IRAM0_NWE,
    parameter int DMA_MAX_WAIT = 8,
    parameter int RD_LAT       = IRAM0_RD_LAT
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic           CoreEn,
    input  logic           CoreWr,
    input  logic [AW-1:0]  CoreAddr,
    input  logic [NWE-1:0] CoreWordEn,
    input  logic [DW-1:0]  CoreWrData,
    input  logic           CoreLoadStore,
    output logic           CoreBusy,
    output logic [DW-1:0]  CoreData,
    input  logic           DmaReq,
    input  logic           DmaWr,
    input  logic [AW-1:0]  DmaAddr,
    input  logic [NWE-1:0] DmaWordEn,
    input  logic [DW-1:0]  DmaWrData,
    output logic           DmaGnt,
    output logic           DmaRdValid,
    output logic [DW-1:0]  DmaRdData,
    output logic           IRam0En,
    output logic           IRam0Wr,
    output logic [AW-1:0]  IRam0Addr,
    output logic [NWE-1:0] IRam0WordEn,
    output logic [DW-1:0]  IRam0WrData,
    output logic           IRam0LoadStore,
    input  logic [DW-1:0]  IRam0Data,
    output logic [15:0]    ConflictCount
);

    // Wait counter only needs to reach DMA_MAX_WAIT.
    localparam int             WCW      = (DMA_MAX_WAIT < 2) ? 1 : $clog2(DMA_MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(DMA_MAX_WAIT);

    logic [WCW-1:0] r_wait;
    logic [15:0]    r_conflict;
    logic           w_force;
    logic           w_dma_win;
    logic           w_core_acc;
    rd_tag_t        w_tag_in;
    rd_tag_t        w_tag_out;

    // Everything that reaches the macro is gated by Reset so no access can
    // slip out while the block is held in reset.
    assign w_force    = (DMA_MAX_WAIT == 0) || (r_wait >= WAIT_MAX);
    assign w_dma_win  = ~Reset & DmaReq & (~CoreEn | w_force);
    assign w_core_acc = ~Reset & CoreEn & ~w_dma_win;

    assign DmaGnt   = w_dma_win;
    assign CoreBusy = CoreEn & w_dma_win;

    assign IRam0En        = w_dma_win | w_core_acc;
    assign IRam0Wr        = w_dma_win ? DmaWr     : (w_core_acc & CoreWr);
    assign IRam0Addr      = w_dma_win ? DmaAddr   : CoreAddr;
    assign IRam0WordEn    = w_dma_win ? DmaWordEn : CoreWordEn;
    assign IRam0WrData    = w_dma_win ? DmaWrData : CoreWrData;
    assign IRam0LoadStore = w_core_acc & CoreLoadStore;

    // Waits accumulate only while DMA is actually asking and losing; a grant
    // or a dropped request starts the count again, so after a forced win
    // the core takes the next conflict.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_wait <= '0;
        end else if (DmaReq && !w_dma_win) begin
            if (r_wait != WAIT_MAX) begin
                r_wait <= r_wait + 1'b1;
            end
        end else begin
            r_wait <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_conflict <= '0;
        end else if (CoreEn && DmaReq && (r_conflict != 16'hFFFF)) begin
            r_conflict <= r_conflict + 16'd1;
        end
    end

    assign ConflictCount = r_conflict;

    // Writes carry no tag; only reads expect a return cycle.
    assign w_tag_in.valid = IRam0En & ~IRam0Wr;
    assign w_tag_in.owner = w_dma_win ? OWN_DMA : OWN_CORE;

    hifi4_iram0_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .i_clk   (CLK),
        .i_reset (Reset),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    assign DmaRdValid = ~Reset & w_tag_out.valid & (w_tag_out.owner == OWN_DMA);
    assign DmaRdData  = IRam0Data;
    // The core counts its own latency, so its data is passed straight through.
    assign CoreData   = IRam0Data;

endmodule

// File: tb/tb_hifi4_iram0_arbiter.sv
// Bench for hifi4_iram0_arbiter: a behavioural 2-cycle IRAM0 macro, a
// reference arbitration model, and scoreboard queues of expected read data.
module tb_hifi4_iram0_arbiter;
    import hifi4_iram0_arb_pkg::*;

    localparam int AW   = 12;
    localparam int DW   = 128;
    localparam int NWE  = 4;
    localparam int MAXW = 8;

    logic           CLK = 1'b0;
    logic           Reset = 1'b1;
    logic           CoreEn = 1'b0, CoreWr = 1'b0, CoreLoadStore = 1'b0;
    logic [AW-1:0]  CoreAddr = '0;
    logic [NWE-1:0] CoreWordEn = '0;
    logic [DW-1:0]  CoreWrData = '0;
    logic           CoreBusy;
    logic [DW-1:0]  CoreData;
    logic           DmaReq = 1'b0, DmaWr = 1'b0;
    logic [AW-1:0]  DmaAddr = '0;
    logic [NWE-1:0] DmaWordEn = '0;
    logic [DW-1:0]  DmaWrData = '0;
    logic           DmaGnt, DmaRdValid;
    logic [DW-1:0]  DmaRdData;
    logic           IRam0En, IRam0Wr, IRam0LoadStore;
    logic [AW-1:0]  IRam0Addr;
    logic [NWE-1:0] IRam0WordEn;
    logic [DW-1:0]  IRam0WrData, IRam0Data;
    logic [15:0]    ConflictCount;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    hifi4_iram0_arbiter #(.DMA_MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .Reset(Reset),
        .CoreEn(CoreEn), .CoreWr(CoreWr), .CoreAddr(CoreAddr), .CoreWordEn(CoreWordEn),
        .CoreWrData(CoreWrData), .CoreLoadStore(CoreLoadStore),
        .CoreBusy(CoreBusy), .CoreData(CoreData),
        .DmaReq(DmaReq), .DmaWr(DmaWr), .DmaAddr(DmaAddr), .DmaWordEn(DmaWordEn),
        .DmaWrData(DmaWrData), .DmaGnt(DmaGnt), .DmaRdValid(DmaRdValid), .DmaRdData(DmaRdData),
        .IRam0En(IRam0En), .IRam0Wr(IRam0Wr), .IRam0Addr(IRam0Addr), .IRam0WordEn(IRam0WordEn),
        .IRam0WrData(IRam0WrData), .IRam0LoadStore(IRam0LoadStore), .IRam0Data(IRam0Data),
        .ConflictCount(ConflictCount)
    );

    // ---------------- behavioural IRAM0 macro ----------------
    logic [DW-1:0] mem [4096];
    logic [DW-1:0] mem_p1, mem_p2;
    always @(posedge CLK) begin
        mem_p2 <= mem_p1;
        if (IRam0En && !IRam0Wr) mem_p1 <= mem[IRam0Addr];
        else                     mem_p1 <= {4{32'hBAD0BAD0}};
        if (IRam0En && IRam0Wr) begin
            for (int w = 0; w < NWE; w++) begin
                if (IRam0WordEn[w]) mem[IRam0Addr][w*32 +: 32] <= IRam0WrData[w*32 +: 32];
            end
        end
    end
    assign IRam0Data = mem_p2;

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] a;
        a = i;
        return {a ^ 32'hC0DE0000, ~a, a * 32'h9E3779B9, a + 32'h12345678};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [NWE-1:0] we);
        logic [DW-1:0] r;
        r = old;
        for (int w = 0; w < NWE; w++) if (we[w]) r[w*32 +: 32] = nw[w*32 +: 32];
        return r;
    endfunction

    // ---------------- scoreboard / reference model ----------------
    logic [DW-1:0] shadow [4096];
    logic [DW-1:0] exp_q[$];
    int            due_q[$];
    logic [DW-1:0] core_exp_q[$];
    int            core_due_q[$];
    int            ref_wait = 0;
    logic [15:0]   ref_cc = '0;
    logic          mon_en = 1'b0;

    always @(negedge CLK) begin
        logic exp_gnt, exp_cacc;
        if (mon_en) begin
            exp_gnt  = !Reset && DmaReq && (!CoreEn || ref_wait >= MAXW);
            exp_cacc = !Reset && CoreEn && !exp_gnt;
            chk("gnt", DmaGnt, exp_gnt);
            chk("busy", CoreBusy, CoreEn && exp_gnt);
            chk("iram_en", IRam0En, exp_gnt || exp_cacc);
            chk("cc", ConflictCount, ref_cc);
            if (exp_gnt)
                chk("iram_dma_ctl", {IRam0Wr, IRam0LoadStore, IRam0WordEn, IRam0Addr},
                    {DmaWr, 1'b0, DmaWordEn, DmaAddr});
            else if (exp_cacc)
                chk("iram_core_ctl", {IRam0Wr, IRam0LoadStore, IRam0WordEn, IRam0Addr},
                    {CoreWr, CoreLoadStore, CoreWordEn, CoreAddr});
            if (Reset) begin
                chk("rdv_in_reset", DmaRdValid, 1'b0);
                exp_q.delete(); due_q.delete(); core_exp_q.delete(); core_due_q.delete();
                ref_wait = 0;
                ref_cc   = '0;
            end else begin
                // returns
                if (DmaRdValid) begin
                    if (exp_q.size() == 0) chk("dma_spurious", 1'b1, 1'b0);
                    else begin
                        chk("dma_data", DmaRdData, exp_q.pop_front());
                        chk("dma_lat", due_q.pop_front(), cyc);
                    end
                end
                while (due_q.size() > 0 && due_q[0] < cyc) begin
                    chk("dma_missing", 1'b0, 1'b1);
                    void'(due_q.pop_front());
                    void'(exp_q.pop_front());
                end
                if (core_due_q.size() > 0 && core_due_q[0] == cyc) begin
                    chk("core_data", CoreData, core_exp_q.pop_front());
                    void'(core_due_q.pop_front());
                end
                // issues
                if (exp_gnt) begin
                    if (DmaWr) shadow[DmaAddr] = merge(shadow[DmaAddr], DmaWrData, DmaWordEn);
                    else begin
                        exp_q.push_back(shadow[DmaAddr]);
                        due_q.push_back(cyc + 2);
                    end
                end else if (exp_cacc) begin
                    if (CoreWr) shadow[CoreAddr] = merge(shadow[CoreAddr], CoreWrData, CoreWordEn);
                    else begin
                        core_exp_q.push_back(shadow[CoreAddr]);
                        core_due_q.push_back(cyc + 2);
                    end
                end
                if (CoreEn && DmaReq && ref_cc != 16'hFFFF) ref_cc = ref_cc + 16'd1;
                if (DmaReq && !exp_gnt) ref_wait = (ref_wait >= MAXW) ? MAXW : ref_wait + 1;
                else                    ref_wait = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_all();
        CoreEn = 1'b0; CoreWr = 1'b0; DmaReq = 1'b0; DmaWr = 1'b0;
    endtask

    task automatic core_drive(input logic wr, input logic [AW-1:0] a, input logic [NWE-1:0] we,
                              input logic [DW-1:0] d);
        CoreEn = 1'b1; CoreWr = wr; CoreAddr = a; CoreWordEn = we; CoreWrData = d;
        CoreLoadStore = a[0];
    endtask

    task automatic dma_drive(input logic wr, input logic [AW-1:0] a, input logic [NWE-1:0] we,
                             input logic [DW-1:0] d);
        DmaReq = 1'b1; DmaWr = wr; DmaAddr = a; DmaWordEn = we; DmaWrData = d;
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        repeat (n) step();
        Reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic dma_granted;
        int   k;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = pat(i);
            shadow[i] = pat(i);
        end
        mem[12'h010]    = {16{8'hA5}};
        shadow[12'h010] = {16{8'hA5}};
        mem[12'hFFF]    = {4{32'hDEADBEEF}};
        shadow[12'hFFF] = {4{32'hDEADBEEF}};

        // Reset held with both requesters asking.
        repeat (2) @(posedge CLK);
        #1;
        mon_en = 1'b1;
        core_drive(1'b0, 12'h001, 4'hF, '0);
        dma_drive(1'b0, 12'h002, 4'hF, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("rst_en", IRam0En, 1'b0);
            chk("rst_gnt", DmaGnt, 1'b0);
            chk("rst_busy", CoreBusy, 1'b0);
            chk("rst_cc", ConflictCount, 16'd0);
            step();
        end
        idle_all();
        Reset = 1'b0;
        repeat (2) step();

        // DMA-only read of 0x010.
        dma_drive(1'b0, 12'h010, 4'hF, '0);
        @(negedge CLK); chk("dma_rd_gnt", DmaGnt, 1'b1);
        step(); idle_all();
        @(negedge CLK); chk("dma_rd_n1", DmaRdValid, 1'b0);
        @(negedge CLK); chk("dma_rd_n2", DmaRdValid, 1'b1);
        chk("dma_rd_data", DmaRdData, {16{8'hA5}});
        @(negedge CLK); chk("dma_rd_n3", DmaRdValid, 1'b0);
        repeat (2) step();

        // Starvation limit: DMA loses MAXW conflicts, then is forced.
        do_reset(2);
        dma_drive(1'b0, 12'h020, 4'hF, '0);
        for (k = 1; k <= MAXW + 1; k++) begin
            core_drive(1'b0, AW'(k), 4'hF, '0);
            @(negedge CLK);
            chk("starve_gnt", DmaGnt, (k == MAXW + 1));
            if (k == MAXW + 1) chk("forced_busy", CoreBusy, 1'b1);
            step();
        end
        dma_drive(1'b0, 12'h021, 4'hF, '0);
        core_drive(1'b0, 12'h030, 4'hF, '0);
        @(negedge CLK);
        chk("after_force_gnt", DmaGnt, 1'b0);
        chk("cc_nine", ConflictCount, 16'd9);
        step();
        idle_all();
        repeat (4) step();

        // DMA masked write to 0xFFF, then core read of it.
        dma_drive(1'b1, 12'hFFF, 4'b0101, 128'h3333_2222_1111_0000);
        step(); idle_all();
        core_drive(1'b0, 12'hFFF, 4'hF, '0);
        step(); idle_all();
        step();
        @(negedge CLK);
        chk("masked_wr", CoreData, 128'hDEADBEEF_00000000_DEADBEEF_11110000);
        repeat (2) step();

        // Core read then DMA read on consecutive cycles.
        core_drive(1'b0, 12'h040, 4'hF, '0);
        step(); idle_all();
        dma_drive(1'b0, 12'h041, 4'hF, '0);
        step(); idle_all();
        @(negedge CLK); chk("intl_core_slot", DmaRdValid, 1'b0);
        @(negedge CLK); chk("intl_dma_slot", DmaRdValid, 1'b1);
        chk("intl_dma_data", DmaRdData, pat(12'h041));
        repeat (2) step();

        // DMA read then reset on the next cycle: the read never returns.
        dma_drive(1'b0, 12'h050, 4'hF, '0);
        step(); idle_all();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); chk("flushed_rdv", DmaRdValid, 1'b0);
            step();
        end

        // Random mixed traffic.
        dma_granted = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 1)
                core_drive($urandom_range(0, 3) == 0, AW'($urandom_range(0, 31)),
                           NWE'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
            else CoreEn = 1'b0;
            if (!DmaReq || dma_granted) begin
                if ($urandom_range(0, 9) < 4)
                    dma_drive($urandom_range(0, 2) == 0, AW'($urandom_range(0, 31)),
                              NWE'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
                else DmaReq = 1'b0;
            end
            @(negedge CLK);
            dma_granted = DmaGnt;
            step();
        end
        idle_all();
        repeat (4) step();

        // Long conflict run: counter must stick at its maximum.
        core_drive(1'b0, 12'h001, 4'hF, '0);
        dma_drive(1'b0, 12'h002, 4'hF, '0);
        repeat (70000) step();
        @(negedge CLK);
        chk("cc_saturate", ConflictCount, 16'hFFFF);
        step();
        idle_all();
        repeat (4) step();

        chk("dma_q_empty", exp_q.size(), 0);
        chk("core_q_empty", core_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
